// File: rtl/stopwatch_uart_tx.sv
// Stopwatch status reporter: sends "<mode><digit>[CR LF]" over the UART transmit port on every change.
// Define STOPWATCH_TX_CRLF_EN to append CR/LF to each frame (4-byte frames instead of 2).
module stopwatch_uart_tx #(
    parameter int GAP = 1
) (
    input  logic       hz100,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic [3:0] count,
    input  logic       txready,
    output logic [7:0] txdata,
    output logic       txclk,
    output logic       busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

`ifdef STOPWATCH_TX_CRLF_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd1;
`endif

    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    function automatic logic [7:0] mode_char(input logic [2:0] m);
        case (m)
            3'b100:  mode_char = 8'h49;
            3'b001:  mode_char = 8'h52;
            3'b010:  mode_char = 8'h43;
            default: mode_char = 8'h58;
        endcase
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] c);
        digit_char = (c <= 4'd9) ? (8'h30 + {4'h0, c}) : 8'h3F;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] m, input logic [3:0] c,
                                              input logic [1:0] idx);
        case (idx)
            2'd0:    frame_byte = mode_char(m);
            2'd1:    frame_byte = digit_char(c);
`ifdef STOPWATCH_TX_CRLF_EN
            2'd2:    frame_byte = 8'h0D;
            2'd3:    frame_byte = 8'h0A;
`endif
            default: frame_byte = 8'h00;
        endcase
    endfunction

    logic [1:0] state;
    logic [1:0] idx;
    logic [3:0] gap_cnt;
    logic [2:0] snap_mode;
    logic [3:0] snap_count;
    logic [2:0] prev_mode;
    logic [3:0] prev_count;
    logic       pending;

    logic       chg;
    logic       last;
    logic [1:0] adv_state;
    logic [1:0] adv_idx;
    logic [7:0] adv_byte;

    assign busy = (state != S_IDLE);
    assign chg  = ({mode, count} != {prev_mode, prev_count});
    assign last = (idx == LAST_IDX);

    // Where the FSM goes once a byte's strobe (and any gap) is finished.
    always_comb begin
        adv_state = S_WAIT;
        adv_idx   = idx + 2'd1;
        adv_byte  = frame_byte(snap_mode, snap_count, idx + 2'd1);
        if (last) begin
            adv_state = S_IDLE;
            adv_idx   = 2'd0;
            adv_byte  = 8'h00;
        end
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            gap_cnt    <= '0;
            snap_mode  <= 3'b100;
            snap_count <= '0;
            prev_mode  <= 3'b100;
            prev_count <= '0;
            pending    <= 1'b1;
            txdata     <= '0;
            txclk      <= 1'b0;
        end else begin
            prev_mode  <= mode;
            prev_count <= count;
            if (chg && busy)
                pending <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (chg || pending) begin
                        snap_mode  <= mode;
                        snap_count <= count;
                        pending    <= 1'b0;
                        idx        <= 2'd0;
                        txdata     <= frame_byte(mode, count, 2'd0);
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (txready) begin
                        txclk <= 1'b1;
                        state <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    txclk <= 1'b0;
                    if (GAP > 0) begin
                        gap_cnt <= '0;
                        txdata  <= '0;
                        state   <= S_GAP;
                    end else begin
                        idx    <= adv_idx;
                        txdata <= adv_byte;
                        state  <= adv_state;
                    end
                end
                default: begin
                    if (gap_cnt == GAP_LAST) begin
                        idx    <= adv_idx;
                        txdata <= adv_byte;
                        state  <= adv_state;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_uart_tx.sv
// Directed bench for stopwatch_uart_tx: startup, stall, coalesce, illegal codes, mid-frame reset.
module tb_stopwatch_uart_tx;

    localparam int GAP = 1;
    localparam int P   = 2 + GAP;
`ifdef STOPWATCH_TX_CRLF_EN
    localparam int NB = 4;
`else
    localparam int NB = 2;
`endif

    logic       hz100 = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] mode  = 3'b100;
    logic [3:0] count = 4'd0;
    logic       txready = 1'b1;
    logic [7:0] txdata;
    logic       txclk;
    logic       busy;

    int n_cmp = 0;
    int n_mis = 0;

    stopwatch_uart_tx #(.GAP(GAP)) dut (
        .hz100  (hz100),
        .reset  (reset),
        .mode   (mode),
        .count  (count),
        .txready(txready),
        .txdata (txdata),
        .txclk  (txclk),
        .busy   (busy)
    );

    always #5 hz100 = ~hz100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Checks {busy,txclk,txdata} once per cycle at negedge from frame offset start..stop.
    // Offset 0 is the cycle right after the trigger edge; offset NB*P is the first idle cycle.
    task automatic check_frame(input string name, input logic [7:0] b [4],
                               input int start, input int stop);
        logic [9:0] exp;
        for (int off = start; off <= stop; off++) begin
            if (off >= NB * P) begin
                exp = 10'h000;
            end else if (off % P == 0) begin
                exp = {2'b10, b[off / P]};
            end else if (off % P == 1) begin
                exp = {2'b11, b[off / P]};
            end else begin
                exp = {2'b10, 8'h00};
            end
            check($sformatf("%s off%0d", name, off), {22'h0, busy, txclk, txdata}, {22'h0, exp});
            if (off < stop)
                @(negedge hz100);
        end
    endtask

    initial begin
        repeat (3) @(negedge hz100);
        check("reset_state", {22'h0, busy, txclk, txdata}, 32'h0);

        // Startup report after reset release.
        reset = 1'b0;
        @(negedge hz100);
        check_frame("startup", '{8'h49, 8'h30, 8'h0D, 8'h0A}, 0, NB * P);

        // Stall in S_WAIT while txready is low.
        mode = 3'b001;
        count = 4'd7;
        txready = 1'b0;
        @(negedge hz100);
        for (int i = 0; i < 5; i++) begin
            check("stall", {22'h0, busy, txclk, txdata}, {22'h0, 2'b10, 8'h52});
            @(negedge hz100);
        end
        txready = 1'b1;
        @(negedge hz100);
        check_frame("stall_resume", '{8'h52, 8'h37, 8'h0D, 8'h0A}, 1, NB * P);

        // Two changes during one frame coalesce into one follow-up frame.
        count = 4'd3;
        @(negedge hz100);
        fork
            check_frame("coal_first", '{8'h52, 8'h33, 8'h0D, 8'h0A}, 0, NB * P);
            begin
                repeat (2) @(negedge hz100);
                count = 4'd4;
                repeat (3) @(negedge hz100);
                count = 4'd5;
            end
        join
        @(negedge hz100);
        check_frame("coal_follow", '{8'h52, 8'h35, 8'h0D, 8'h0A}, 0, NB * P);
        for (int i = 0; i < 3; i++) begin
            @(negedge hz100);
            check("no_extra", {22'h0, busy, txclk, txdata}, 32'h0);
        end

        // Illegal mode and digit codes.
        mode = 3'b011;
        count = 4'd12;
        @(negedge hz100);
        check_frame("illegal", '{8'h58, 8'h3F, 8'h0D, 8'h0A}, 0, NB * P);

        // Reset in the gap after byte 1, then a fresh startup frame.
        mode = 3'b100;
        count = 4'd2;
        @(negedge hz100);
        check_frame("pre_rst", '{8'h49, 8'h32, 8'h0D, 8'h0A}, 0, P + 2);
        reset = 1'b1;
        #1;
        check("rst_async", {22'h0, busy, txclk, txdata}, 32'h0);
        count = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge hz100);
            check("rst_hold", {22'h0, busy, txclk, txdata}, 32'h0);
        end
        reset = 1'b0;
        @(negedge hz100);
        check_frame("restart", '{8'h49, 8'h30, 8'h0D, 8'h0A}, 0, NB * P);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
